// File: rtl/redmule_tcdm_arbiter.sv
// redmule_tcdm_arbiter: round-robin arbiter sharing RedMulE's wide TCDM port among the streamers.
// Optional macro REDMULE_ARB_STORE_PRIO_EN gives the Z store sink (index NReq-1) fixed priority.
module redmule_tcdm_arbiter #(
  parameter int unsigned NReq           = 7,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned DataW          = 288,
  parameter int unsigned AddrW          = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clear_i,
  input  logic [NReq-1:0]                     req_i,
  input  logic [NReq-1:0]                     wen_i,
  input  logic [NReq-1:0][AddrW-1:0]          add_i,
  input  logic [NReq-1:0][DataW-1:0]          data_i,
  input  logic [NReq-1:0][DataW/8-1:0]        be_i,
  output logic [NReq-1:0]                     gnt_o,
  output logic [NReq-1:0]                     r_valid_o,
  output logic [DataW-1:0]                    r_data_o,
  output logic                                tcdm_req_o,
  output logic                                tcdm_wen_o,
  output logic [AddrW-1:0]                    tcdm_add_o,
  output logic [DataW-1:0]                    tcdm_data_o,
  output logic [DataW/8-1:0]                  tcdm_be_o,
  input  logic                                tcdm_gnt_i,
  input  logic                                tcdm_r_valid_i,
  input  logic [DataW-1:0]                    tcdm_r_data_i,
  output logic                                busy_o,
  output logic [$clog2(MaxOutstanding):0]     outstanding_o,
  output logic                                err_o
);

  localparam int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;

`ifdef REDMULE_ARB_STORE_PRIO_EN
  localparam int unsigned RrSpan = NReq - 1;
`else
  localparam int unsigned RrSpan = NReq;
`endif

  // Requester index at offset k from base, wrapping inside the round-robin span.
  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base,
                                             input int unsigned     k,
                                             input int unsigned     n);
    return IdxW'((32'(base) + k) % n);
  endfunction

  logic [IdxW-1:0] rr_ptr, rr_next;
  logic            locked;
  logic [IdxW-1:0] lock_idx;
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count;
  logic [IdxW-1:0] id_mem [MaxOutstanding];
  logic [IdxW-1:0] head;

  logic [NReq-1:0] eligible;
  logic            fifo_full;
  logic            lock_hold;
  logic            win_valid;
  logic [IdxW-1:0] win;
  logic            hs;
  logic            push;
  logic            pop;

  assign fifo_full = (count == CntW'(MaxOutstanding));
  assign eligible  = req_i & ~(wen_i & {NReq{fifo_full}});
  assign lock_hold = locked & req_i[lock_idx];
  assign head      = id_mem[rd_ptr];

  // Winner selection: a held lock overrides everything, otherwise scan from rr_ptr.
  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    if (lock_hold) begin
      win_valid = 1'b1;
      win       = lock_idx;
    end else begin
`ifdef REDMULE_ARB_STORE_PRIO_EN
      if (eligible[NReq-1]) begin
        win_valid = 1'b1;
        win       = IdxW'(NReq - 1);
      end
`endif
      for (int unsigned k = 0; k < RrSpan; k++) begin
        if (!win_valid && eligible[rr_idx(rr_ptr, k, RrSpan)]) begin
          win_valid = 1'b1;
          win       = rr_idx(rr_ptr, k, RrSpan);
        end
      end
    end
  end

  assign hs   = win_valid & tcdm_gnt_i;
  assign push = hs & wen_i[win];
  assign pop  = tcdm_r_valid_i & (count != '0);

`ifdef REDMULE_ARB_STORE_PRIO_EN
  // Store-sink handshakes leave the round-robin position untouched.
  assign rr_next = (win == IdxW'(NReq - 1)) ? rr_ptr : rr_idx(win, 1, RrSpan);
`else
  assign rr_next = rr_idx(win, 1, RrSpan);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (clear_i) begin
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else begin
      if (hs) begin
        rr_ptr <= rr_next;
      end
      locked <= win_valid & ~tcdm_gnt_i;
      if (win_valid && !tcdm_gnt_i) begin
        lock_idx <= win;
      end
    end
  end

  // Read-ID FIFO bookkeeping plus the sticky orphan-response flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_o  <= 1'b0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (tcdm_r_valid_i && (count == '0)) begin
        err_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[wr_ptr] <= win;
    end
  end

  always_comb begin
    gnt_o = '0;
    if (win_valid) begin
      gnt_o[win] = tcdm_gnt_i;
    end
  end

  always_comb begin
    r_valid_o = '0;
    if (pop) begin
      r_valid_o[head] = 1'b1;
    end
  end

  assign r_data_o      = tcdm_r_data_i;
  assign tcdm_req_o    = win_valid;
  assign tcdm_wen_o    = wen_i[win];
  assign tcdm_add_o    = add_i[win];
  assign tcdm_data_o   = data_i[win];
  assign tcdm_be_o     = be_i[win];
  assign busy_o        = (|req_i) | (count != '0);
  assign outstanding_o = count;

endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// Directed self-checking bench for redmule_tcdm_arbiter.
// Honours REDMULE_ARB_STORE_PRIO_EN for the store-priority expectations.
module tb_redmule_tcdm_arbiter;

  localparam int NReq  = 7;
  localparam int MaxO  = 4;
  localparam int DataW = 288;
  localparam int AddrW = 32;

  logic                         clk;
  logic                         rst_n;
  logic                         clear_i;
  logic [NReq-1:0]              req_i;
  logic [NReq-1:0]              wen_i;
  logic [NReq-1:0][AddrW-1:0]   add_i;
  logic [NReq-1:0][DataW-1:0]   data_i;
  logic [NReq-1:0][DataW/8-1:0] be_i;
  logic [NReq-1:0]              gnt_o;
  logic [NReq-1:0]              r_valid_o;
  logic [DataW-1:0]             r_data_o;
  logic                         tcdm_req_o;
  logic                         tcdm_wen_o;
  logic [AddrW-1:0]             tcdm_add_o;
  logic [DataW-1:0]             tcdm_data_o;
  logic [DataW/8-1:0]           tcdm_be_o;
  logic                         tcdm_gnt_i;
  logic                         tcdm_r_valid_i;
  logic [DataW-1:0]             tcdm_r_data_i;
  logic                         busy_o;
  logic [$clog2(MaxO):0]        outstanding_o;
  logic                         err_o;

  int checks = 0;
  int fails  = 0;
  logic [NReq-1:0] exp_gnt;

  redmule_tcdm_arbiter #(
    .NReq(NReq), .MaxOutstanding(MaxO), .DataW(DataW), .AddrW(AddrW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i),
    .req_i(req_i), .wen_i(wen_i), .add_i(add_i), .data_i(data_i), .be_i(be_i),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_data_o(r_data_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_wen_o(tcdm_wen_o), .tcdm_add_o(tcdm_add_o),
    .tcdm_data_o(tcdm_data_o), .tcdm_be_o(tcdm_be_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .busy_o(busy_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AddrW-1:0] addrOf(input int i);
    return 32'h1000_0000 + 32'(i * 16);
  endfunction

  function automatic logic [DataW-1:0] wdataOf(input int i);
    return {9{32'hD000_0000 + 32'(i)}};
  endfunction

  function automatic logic [DataW-1:0] rdataOf(input int i);
    return {9{32'hA5A5_0000 + 32'(i)}};
  endfunction

  // Drive one cycle's inputs on the falling edge, leaving time to settle before checks.
  task automatic applyStimulus(input logic [NReq-1:0] req, input logic [NReq-1:0] wen,
                               input logic gnt, input logic rv, input logic clr,
                               input logic [DataW-1:0] rdata);
    @(negedge clk);
    req_i          = req;
    wen_i          = wen;
    tcdm_gnt_i     = gnt;
    tcdm_r_valid_i = rv;
    clear_i        = clr;
    tcdm_r_data_i  = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    clear_i        = 1'b0;
    req_i          = '0;
    wen_i          = '0;
    tcdm_gnt_i     = 1'b0;
    tcdm_r_valid_i = 1'b0;
    tcdm_r_data_i  = '0;
    for (int i = 0; i < NReq; i++) begin
      add_i[i]  = addrOf(i);
      data_i[i] = wdataOf(i);
      be_i[i]   = 36'(i + 1);
    end
    #2 rst_n = 1'b0;
    #6;
    $display("[TB] reset state");
    checkOutput("rst_gnt", gnt_o, 0);
    checkOutput("rst_rvalid", r_valid_o, 0);
    checkOutput("rst_tcdm_req", tcdm_req_o, 0);
    checkOutput("rst_outstanding", outstanding_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] rotation");
    for (int c = 0; c < 10; c++) begin
      applyStimulus(7'h7F, 7'h7F, 1'b1, c >= 2, 1'b0, rdataOf(c - 2));
      checkOutput("rot_gnt", gnt_o, 1 << (c % NReq));
      checkOutput("rot_add", tcdm_add_o, addrOf(c % NReq));
      if (c >= 2) begin
        checkOutput("rot_rvalid", r_valid_o, 1 << ((c - 2) % NReq));
        checkOutput("rot_rdata", r_data_o, rdataOf(c - 2));
      end else begin
        checkOutput("rot_rvalid_idle", r_valid_o, 0);
      end
    end
    checkOutput("rot_wdata", tcdm_data_o, wdataOf(2));
    checkOutput("rot_be", tcdm_be_o, 36'd3);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b1, 1'b0, rdataOf(8));
    checkOutput("rot_out2", outstanding_o, 2);
    checkOutput("rot_drain0", r_valid_o, 7'h02);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b1, 1'b0, rdataOf(9));
    checkOutput("rot_drain1", r_valid_o, 7'h04);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("rot_out0", outstanding_o, 0);

    $display("[TB] lock");
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b0, 1'b1, '0);
    applyStimulus(7'b0010100, 7'h7F, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("lock_add_c1", tcdm_add_o, addrOf(2));
    checkOutput("lock_req_c1", tcdm_req_o, 1);
    checkOutput("lock_gnt_c1", gnt_o, 0);
    applyStimulus(7'b0010101, 7'h7F, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("lock_add_c2", tcdm_add_o, addrOf(2));
    applyStimulus(7'b0010101, 7'h7F, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("lock_add_c3", tcdm_add_o, addrOf(2));
    checkOutput("lock_gnt_c3", gnt_o, 0);
    applyStimulus(7'b0010101, 7'h7F, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("lock_gnt_c4", gnt_o, 7'b0000100);
    checkOutput("lock_add_c4", tcdm_add_o, addrOf(2));
    applyStimulus(7'b0010001, 7'h7F, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("lock_next4", gnt_o, 7'b0010000);
    applyStimulus(7'b0000001, 7'h7F, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("lock_then0", gnt_o, 7'b0000001);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b1, 1'b0, rdataOf(2));
    checkOutput("lock_out3", outstanding_o, 3);
    checkOutput("lock_resp2", r_valid_o, 7'b0000100);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b1, 1'b0, rdataOf(4));
    checkOutput("lock_resp4", r_valid_o, 7'b0010000);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b1, 1'b0, rdataOf(0));
    checkOutput("lock_resp0", r_valid_o, 7'b0000001);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("lock_out0", outstanding_o, 0);

    $display("[TB] backpressure");
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b0, 1'b1, '0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(7'h01, 7'h7F, 1'b1, 1'b0, 1'b0, '0);
      checkOutput("bp_gnt", gnt_o, 7'h01);
    end
    applyStimulus(7'h01, 7'h7F, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("bp_full_req", tcdm_req_o, 0);
    checkOutput("bp_full_gnt", gnt_o, 0);
    checkOutput("bp_out4", outstanding_o, 4);
    checkOutput("bp_busy", busy_o, 1);
    applyStimulus(7'h41, 7'h3F, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("bp_wr_gnt", gnt_o, 7'h40);
    checkOutput("bp_wr_wen", tcdm_wen_o, 0);
    applyStimulus(7'h01, 7'h7F, 1'b1, 1'b1, 1'b0, rdataOf(0));
    checkOutput("bp_out4_after_wr", outstanding_o, 4);
    checkOutput("bp_pop_full_req", tcdm_req_o, 0);
    checkOutput("bp_pop_rvalid", r_valid_o, 7'h01);
    applyStimulus(7'h01, 7'h7F, 1'b1, 1'b1, 1'b0, rdataOf(0));
    checkOutput("bp_out3", outstanding_o, 3);
    checkOutput("bp_pushpop_gnt", gnt_o, 7'h01);
    checkOutput("bp_pushpop_rvalid", r_valid_o, 7'h01);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b1, 1'b0, rdataOf(0));
    checkOutput("bp_pushpop_hold", outstanding_o, 3);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b1, 1'b0, rdataOf(0));
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b1, 1'b0, rdataOf(0));
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("bp_out0", outstanding_o, 0);

    $display("[TB] error");
    applyStimulus(7'h08, 7'h00, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("err_wr3_gnt", gnt_o, 7'h08);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b1, 1'b0, rdataOf(5));
    checkOutput("err_rvalid", r_valid_o, 0);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("err_set", err_o, 1);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("err_sticky", err_o, 1);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b0, 1'b1, '0);
    applyStimulus(7'h7F, 7'h00, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("err_cleared", err_o, 0);
    checkOutput("err_clr_out", outstanding_o, 0);
    checkOutput("err_clr_rrptr", gnt_o, 7'h01);

    $display("[TB] reset mid-burst");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(7'h02, 7'h7F, 1'b1, 1'b0, 1'b0, '0);
      checkOutput("mid_gnt", gnt_o, 7'h02);
    end
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("mid_out3", outstanding_o, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out", outstanding_o, 0);
    checkOutput("mid_rst_busy", busy_o, 0);
    checkOutput("mid_rst_err", err_o, 0);
    checkOutput("mid_rst_gnt", gnt_o, 0);
    checkOutput("mid_rst_req", tcdm_req_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b1, 1'b0, rdataOf(1));
    checkOutput("mid_orphan_rvalid", r_valid_o, 0);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("mid_orphan_err", err_o, 1);
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b0, 1'b1, '0);

    $display("[TB] store priority");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(7'h42, 7'h00, 1'b1, 1'b0, 1'b0, '0);
`ifdef REDMULE_ARB_STORE_PRIO_EN
      exp_gnt = 7'h40;
`else
      exp_gnt = (k % 2 == 0) ? 7'h02 : 7'h40;
`endif
      checkOutput("prio_gnt", gnt_o, exp_gnt);
    end
    applyStimulus(7'h00, 7'h00, 1'b0, 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
